// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: advances the PC, issues in-order imem reads and buffers
// {pc, instruction} pairs for decode, with flush support for branch redirects.
module if_fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    output logic        pc_write,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        flush,
    output logic        ins_valid,
    output logic [31:0] ins_out,
    output logic [31:0] ins_pc,
    input  logic        id_ready
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    typedef enum logic {
        ST_PRIME,
        ST_RUN
    } state_t;

    state_t state_q, state_d;

    logic [31:0] ins_data_mem [DEPTH];
    logic [31:0] ins_tag_mem  [DEPTH];
    logic [31:0] tag_mem      [DEPTH];

    logic [PW-1:0] ins_wr_q, ins_wr_d;
    logic [PW-1:0] ins_rd_q, ins_rd_d;
    logic [PW-1:0] tag_wr_q, tag_wr_d;
    logic [PW-1:0] tag_rd_q, tag_rd_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;

    logic [CW:0]   occupancy;
    logic [CW-1:0] drop_sum;
    logic          accept;
    logic          resp_keep;
    logic          resp_drop;
    logic          pop;

    assign imem_addr = pc_in;
    assign ins_valid = (count_q != '0);
    assign ins_out   = ins_valid ? ins_data_mem[ins_rd_q] : 32'h0;
    assign ins_pc    = ins_valid ? ins_tag_mem[ins_rd_q]  : 32'h0;

    // Tag FIFO occupancy always equals outstanding, so outstanding doubles as its count.
    assign occupancy = {1'b0, count_q} + {1'b0, outstanding_q};
    assign drop_sum  = drop_cnt_q + outstanding_q;

    always_comb begin
        state_d   = state_q;
        pc_write  = 1'b0;
        imem_req  = 1'b0;
        accept    = 1'b0;
        resp_keep = 1'b0;
        resp_drop = 1'b0;
        pop       = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_PRIME: begin
                    pc_write = !flush;
                    state_d  = ST_RUN;
                end
                default: begin
                    imem_req = !flush && (occupancy < DEPTH_W);
                    accept   = imem_req && imem_ready;
                    pc_write = accept;
                end
            endcase
            resp_keep = imem_rvalid && (drop_cnt_q == '0) && !flush;
            resp_drop = imem_rvalid && (drop_cnt_q != '0) && !flush;
            pop       = ins_valid && id_ready && !flush;
        end
    end

    always_comb begin
        ins_wr_d      = ins_wr_q;
        ins_rd_d      = ins_rd_q;
        tag_wr_d      = tag_wr_q;
        tag_rd_d      = tag_rd_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        if (flush) begin
            ins_wr_d      = '0;
            ins_rd_d      = '0;
            tag_wr_d      = '0;
            tag_rd_d      = '0;
            count_d       = '0;
            outstanding_d = '0;
            // A response landing in the flush cycle is one of the requests being dropped.
            drop_cnt_d    = (imem_rvalid && drop_sum != '0) ? drop_sum - CW'(1) : drop_sum;
        end else begin
            if (resp_keep) ins_wr_d = ins_wr_q + PW'(1);
            if (pop)       ins_rd_d = ins_rd_q + PW'(1);
            if (accept)    tag_wr_d = tag_wr_q + PW'(1);
            if (resp_keep) tag_rd_d = tag_rd_q + PW'(1);
            count_d       = count_q + CW'(resp_keep) - CW'(pop);
            outstanding_d = outstanding_q + CW'(accept) - CW'(resp_keep);
            drop_cnt_d    = drop_cnt_q - CW'(resp_drop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_PRIME;
            ins_wr_q      <= '0;
            ins_rd_q      <= '0;
            tag_wr_q      <= '0;
            tag_rd_q      <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            ins_wr_q      <= ins_wr_d;
            ins_rd_q      <= ins_rd_d;
            tag_wr_q      <= tag_wr_d;
            tag_rd_q      <= tag_rd_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    // Storage arrays carry no reset; the head outputs are gated by ins_valid instead.
    always_ff @(posedge clk) begin
        if (resp_keep) begin
            ins_data_mem[ins_wr_q] <= imem_rdata;
            ins_tag_mem[ins_wr_q]  <= tag_mem[tag_rd_q];
        end
        if (accept) begin
            tag_mem[tag_wr_q] <= pc_in;
        end
    end
endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue with a PC-register model and an in-order memory
// model whose responses can be held back to build up outstanding requests.
module tb_if_fetch_queue;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_in;
    logic        pc_write;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        flush;
    logic        ins_valid;
    logic [31:0] ins_out;
    logic [31:0] ins_pc;
    logic        id_ready;

    logic        load_en;
    logic [31:0] load_val;
    logic        mem_hold;
    logic [31:0] pend_q[$];
    int          acc_cnt;
    int          checks = 0;
    int          errors = 0;
    int          n;

    always #5 clk = ~clk;

    if_fetch_queue #(.DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .pc_in      (pc_in),
        .pc_write   (pc_write),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .flush      (flush),
        .ins_valid  (ins_valid),
        .ins_out    (ins_out),
        .ins_pc     (ins_pc),
        .id_ready   (id_ready)
    );

    // PC register: resets to 0xFFFFFFFC, branch load has priority over advance.
    always @(posedge clk) begin
        if (reset)        pc_in <= 32'hFFFF_FFFC;
        else if (load_en) pc_in <= load_val;
        else if (pc_write) pc_in <= pc_in + 32'd4;
    end

    // In-order memory, data word = 0xA0000000 + (addr >> 2), latency 1 unless held.
    always @(posedge clk) begin
        if (reset) begin
            pend_q.delete();
            imem_rvalid <= 1'b0;
            imem_rdata  <= 32'h0;
            acc_cnt     <= 0;
        end else begin
            if (imem_req && imem_ready) begin
                pend_q.push_back(imem_addr);
                acc_cnt <= acc_cnt + 1;
            end
            if (!mem_hold && pend_q.size() > 0) begin
                imem_rvalid <= 1'b1;
                imem_rdata  <= 32'hA000_0000 + (pend_q[0] >> 2);
                void'(pend_q.pop_front());
            end else begin
                imem_rvalid <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_valid();
        n = 0;
        while (ins_valid !== 1'b1 && n < 12) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; id_ready = 1'b1; imem_ready = 1'b1;
        mem_hold = 1'b0; load_en = 1'b0; load_val = 32'h0;

        // Reset held two cycles, then PRIME, then first request at 0
        repeat (2) @(negedge clk);
        chk("rst_pc_write", 32'(pc_write), 32'd0);
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_ins_valid", 32'(ins_valid), 32'd0);
        chk("rst_ins_out", ins_out, 32'h0);
        chk("rst_ins_pc", ins_pc, 32'h0);
        reset = 1'b0;
        #1;
        chk("prime_pc_write", 32'(pc_write), 32'd1);
        chk("prime_imem_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        chk("run_imem_req", 32'(imem_req), 32'd1);
        chk("run_imem_addr", imem_addr, 32'h0);

        // Streaming: one entry per cycle, no gaps
        @(negedge clk);
        chk("stream_fill_empty", 32'(ins_valid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("stream_valid", 32'(ins_valid), 32'd1);
            chk("stream_pc", ins_pc, 32'(4 * k));
            chk("stream_data", ins_out, 32'hA000_0000 + 32'(k));
            chk("stream_req", 32'(imem_req), 32'd1);
        end

        // Backpressure from a fresh reset: exactly four accepts, then stall
        id_ready = 1'b0;
        do_reset();
        #1;
        chk("bp_prime_pc_write", 32'(pc_write), 32'd1);
        repeat (8) @(negedge clk);
        chk("bp_accepts", 32'(acc_cnt), 32'd4);
        chk("bp_req_off", 32'(imem_req), 32'd0);
        chk("bp_pc_write_off", 32'(pc_write), 32'd0);
        chk("bp_head_pc", ins_pc, 32'h0);
        chk("bp_head_data", ins_out, 32'hA000_0000);
        chk("bp_pc_in", pc_in, 32'h10);
        id_ready = 1'b1;
        #1;
        chk("bp_pop_not_credited", 32'(imem_req), 32'd0);
        @(negedge clk);
        chk("bp_resume_req", 32'(imem_req), 32'd1);
        chk("bp_resume_addr", imem_addr, 32'h10);
        chk("bp_next_head_pc", ins_pc, 32'h4);
        chk("bp_next_head_data", ins_out, 32'hA000_0001);

        // Flush with two outstanding, branch path loads 0x100
        mem_hold = 1'b1;
        do_reset();
        repeat (2) @(negedge clk);
        chk("fl_req_before", 32'(imem_req), 32'd1);
        chk("fl_addr_before", imem_addr, 32'h4);
        @(negedge clk);
        flush = 1'b1; load_en = 1'b1; load_val = 32'h100;
        #1;
        chk("fl_req_masked", 32'(imem_req), 32'd0);
        chk("fl_pc_write_masked", 32'(pc_write), 32'd0);
        @(negedge clk);
        flush = 1'b0; load_en = 1'b0; mem_hold = 1'b0;
        chk("fl_cleared_valid", 32'(ins_valid), 32'd0);
        chk("fl_redirect_addr", imem_addr, 32'h100);
        wait_valid();
        chk("fl_first_valid", 32'(ins_valid), 32'd1);
        chk("fl_first_pc", ins_pc, 32'h100);
        chk("fl_first_data", ins_out, 32'hA000_0040);

        // Flush coinciding with a response, three outstanding
        mem_hold = 1'b1;
        do_reset();
        repeat (3) @(negedge clk);
        @(negedge clk);
        imem_ready = 1'b0; mem_hold = 1'b0;
        @(negedge clk);
        flush = 1'b1; load_en = 1'b1; load_val = 32'h200;
        #1;
        chk("fr_req_masked", 32'(imem_req), 32'd0);
        @(negedge clk);
        flush = 1'b0; load_en = 1'b0; imem_ready = 1'b1;
        wait_valid();
        chk("fr_first_valid", 32'(ins_valid), 32'd1);
        chk("fr_first_pc", ins_pc, 32'h200);
        chk("fr_first_data", ins_out, 32'hA000_0080);
        @(negedge clk);
        chk("fr_second_pc", ins_pc, 32'h204);
        chk("fr_second_data", ins_out, 32'hA000_0081);

        // Memory not ready for three cycles: request and address held, no PC advance
        imem_ready = 1'b0;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("nr_req_held", 32'(imem_req), 32'd1);
            chk("nr_addr_held", imem_addr, 32'h0);
            chk("nr_pc_write", 32'(pc_write), 32'd0);
        end
        @(negedge clk);
        imem_ready = 1'b1;
        #1;
        chk("nr_accept_pc_write", 32'(pc_write), 32'd1);
        chk("nr_accept_addr", imem_addr, 32'h0);
        @(negedge clk);
        chk("nr_next_addr", imem_addr, 32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
